simd_mac_sequencer: RTL

//  Job controller for the 64-lane SIMD MAC array. Accepts a job (vector length K,

---
 rtl/simd_seq_pkg.sv | 26 ++
 rtl/simd_seq_sat_cnt.sv | 29 ++
 rtl/simd_mac_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/simd_seq_pkg.sv
// Shared types and defaults for the SIMD MAC job sequencer.
//   seq_state_e  : sequencer FSM state encoding
//   SEQ_LEN_W    : default width of the job length K
//   SEQ_MAC_LAT  : default MAC pipeline latency after the last operand beat
//   SEQ_CNT_W    : default width of the performance counters
//   drain_cnt_w  : width needed by the drain down-counter for a given latency
package simd_seq_pkg;

  localparam int SEQ_LEN_W   = 16;
  localparam int SEQ_MAC_LAT = 1;
  localparam int SEQ_CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } seq_state_e;

  // The drain counter holds values 0..lat-1; keep at least one bit.
  function automatic int drain_cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/simd_seq_sat_cnt.sv
// Saturating event counter with synchronous clear.
//   clk   in  1  clock
//   rst   in  1  asynchronous reset, active-high, zeroes the count
//   clr   in  1  synchronous clear, has priority over inc
//   inc   in  1  count one event this cycle
//   count out W  current count, sticks at all-ones instead of wrapping
module simd_seq_sat_cnt
  import simd_seq_pkg::*;
#(
  parameter int W = SEQ_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/simd_mac_sequencer.sv
// Job controller for the 64-lane SIMD MAC array. Takes a job (length K and an
// optional accumulator clear), clears the array if asked, streams K operand
// beats under valid/ready, waits out the MAC pipeline and then presents the
// result under valid/ready. Operand and result vectors never pass through here.
//
// Optional feature macro: SIMD_SEQ_PERF_EN adds the CNT_W parameter, the
// perf_clr input and the saturating perf_busy / perf_stall counters.
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      asynchronous reset, active-high
//   cfg_valid  in   1      job request valid
//   cfg_ready  out  1      job request ready (IDLE only)
//   cfg_len    in   LEN_W  number of operand beats K
//   cfg_clr    in   1      clear accumulators before accumulating
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      operand beat ready (ACCUM only)
//   arr_en     out  1      array accumulate enable
//   arr_clr    out  1      array accumulator clear
//   res_valid  out  1      array result final and stable
//   res_ready  in   1      consumer takes the result
//   busy       out  1      job in progress
//   done       out  1      registered pulse after the result handshake
//   perf_clr   in   1      (SIMD_SEQ_PERF_EN) clear both perf counters
//   perf_busy  out  CNT_W  (SIMD_SEQ_PERF_EN) cycles with busy=1
//   perf_stall out  CNT_W  (SIMD_SEQ_PERF_EN) ACCUM cycles without a beat
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a job, cfg_ready high
// CLEAR | single cycle driving arr_clr
// ACCUM | accepting operand beats until K have been taken
// DRAIN | waiting MAC_LAT cycles for the array pipeline to settle
// OUT   | result presented, waiting for res_ready
module simd_mac_sequencer
  import simd_seq_pkg::*;
#(
  parameter int LEN_W   = SEQ_LEN_W,
`ifdef SIMD_SEQ_PERF_EN
  parameter int CNT_W   = SEQ_CNT_W,
`endif
  parameter int MAC_LAT = SEQ_MAC_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             arr_en,
  output logic             arr_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
`ifdef SIMD_SEQ_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_busy,
  output logic [CNT_W-1:0] perf_stall,
`endif
  output logic             done
);

  // A latency below one is treated as one so the drain state always lasts
  // at least a cycle.
  localparam int LAT_EFF = (MAC_LAT < 1) ? 1 : MAC_LAT;
  localparam int DRAIN_W = drain_cnt_w(LAT_EFF);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(LAT_EFF - 1);

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               beat_last;

  assign beat_last = (beat_cnt == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    arr_clr   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_clr) begin
            state_d = ST_CLEAR;
          end else if (cfg_len != '0) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_OUT;
          end
        end
      end
      ST_CLEAR: begin
        arr_clr = 1'b1;
        state_d = (len_q != '0) ? ST_ACCUM : ST_OUT;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && beat_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // arr_en only exists in ACCUM and arr_clr only in CLEAR, so they can
  // never overlap.
  assign arr_en = in_valid & in_ready;
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_q == ST_OUT) && res_ready;
      if (cfg_valid && cfg_ready) begin
        len_q <= cfg_len;
      end
      if (arr_en) begin
        beat_cnt <= beat_last ? '0 : (beat_cnt + LEN_W'(1));
      end
      // Down-counter: preloaded outside DRAIN, terminal count at zero.
      if (state_q == ST_DRAIN) begin
        if (drain_cnt != '0) begin
          drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
      end else begin
        drain_cnt <= DRAIN_LOAD;
      end
    end
  end

`ifdef SIMD_SEQ_PERF_EN
  logic stall_evt;
  assign stall_evt = (state_q == ST_ACCUM) && !in_valid;

  simd_seq_sat_cnt #(.W(CNT_W)) u_perf_busy (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (busy),
    .count (perf_busy)
  );

  simd_seq_sat_cnt #(.W(CNT_W)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (stall_evt),
    .count (perf_stall)
  );
`endif

endmodule
